// File: rtl/mem_wb_skid_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_skid_stage_pkg
// Purpose  : Shared MEM/WB pipeline constants, default widths and payload type.
// Revision : 1.0
// ============================================================================
package mem_wb_skid_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_WB_W   = 2;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] mem_data;
        logic [DEF_DATA_W-1:0] alu_result;
        logic [DEF_REG_AW-1:0] wr_reg;
        logic [DEF_WB_W-1:0]   wb;
    } mem_wb_payload_t;

    function automatic int payload_bits(input int dw, input int aw, input int ww);
        return 2 * dw + aw + ww;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_skid_stage_if
// Purpose  : MEM/WB handshake, payload and writeback bundle.
// Revision : 1.0
// ============================================================================
interface mem_wb_skid_stage_if #(
    parameter int DATA_W = mem_wb_skid_stage_pkg::DEF_DATA_W,
    parameter int REG_AW = mem_wb_skid_stage_pkg::DEF_REG_AW,
    parameter int WB_W   = mem_wb_skid_stage_pkg::DEF_WB_W,
    parameter int CNT_W  = 16
);
    import mem_wb_skid_stage_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_alu_result;
    logic [REG_AW-1:0] in_wr_reg;
    logic [WB_W-1:0]   in_wb;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_mem_data;
    logic [DATA_W-1:0] out_alu_result;
    logic [REG_AW-1:0] out_wr_reg;
    logic [WB_W-1:0]   out_wb;
    logic              wb_wr_en;
    logic [DATA_W-1:0] wb_wr_data;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output in_valid, in_mem_data, in_alu_result, in_wr_reg, in_wb, out_ready,
        input  in_ready, out_valid, out_mem_data, out_alu_result, out_wr_reg,
               out_wb, wb_wr_en, wb_wr_data, retire_cnt
    );

    modport slave (
        input  in_valid, in_mem_data, in_alu_result, in_wr_reg, in_wb, out_ready,
        output in_ready, out_valid, out_mem_data, out_alu_result, out_wr_reg,
               out_wb, wb_wr_en, wb_wr_data, retire_cnt
    );

endinterface
`default_nettype wire

// File: rtl/mem_wb_skid_stage_pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buffer
// Purpose  : Generic 2-entry valid/ready skid register with synchronous flush.
// Revision : 1.0
// ============================================================================
module pipe_skid_buffer #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         flush,
    input  wire logic         i_valid,
    output logic              o_ready,
    input  wire logic [W-1:0] i_data,
    output logic              o_valid,
    input  wire logic         i_ready,
    output logic [W-1:0]      o_data
);
    import mem_wb_skid_stage_pkg::*;

    logic         r_m_valid;
    logic [W-1:0] r_m_data;
    logic         r_s_valid;
    logic [W-1:0] r_s_data;
    logic         w_in_fire;
    logic         w_out_fire;

    // Ready is a pure function of the skid flop, so it never depends on i_ready.
    assign o_ready    = ~r_s_valid;
    assign o_valid    = r_m_valid;
    assign o_data     = r_m_data;
    assign w_in_fire  = i_valid & ~r_s_valid;
    assign w_out_fire = r_m_valid & i_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else if (!r_m_valid || w_out_fire) begin
            if (r_s_valid) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_s_data;
                r_s_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_m_valid <= 1'b1;
                r_m_data  <= i_data;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_s_valid <= 1'b1;
            r_s_data  <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_skid_stage
// Purpose  : MEM/WB boundary with skid buffer, writeback select and retire count.
// Revision : 1.0
// ============================================================================
module mem_wb_skid_stage #(
    parameter int DATA_W = mem_wb_skid_stage_pkg::DEF_DATA_W,
    parameter int REG_AW = mem_wb_skid_stage_pkg::DEF_REG_AW,
    parameter int WB_W   = mem_wb_skid_stage_pkg::DEF_WB_W,
    parameter int CNT_W  = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           flush,
    mem_wb_skid_stage_if.slave  bus
);
    import mem_wb_skid_stage_pkg::*;

    localparam int               P_W       = payload_bits(DATA_W, REG_AW, WB_W);
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [P_W-1:0]   w_in_payload;
    logic [P_W-1:0]   w_out_payload;
    logic             w_out_valid;
    logic             w_out_fire;
    logic [CNT_W-1:0] r_retire_cnt;

    assign w_in_payload = {bus.in_mem_data, bus.in_alu_result, bus.in_wr_reg, bus.in_wb};

    pipe_skid_buffer #(
        .W (P_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  (w_in_payload),
        .o_valid (w_out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out_payload)
    );

    assign {bus.out_mem_data, bus.out_alu_result, bus.out_wr_reg, bus.out_wb} = w_out_payload;
    assign bus.out_valid = w_out_valid;
    assign w_out_fire    = w_out_valid & bus.out_ready;

    // Register 0 is hardwired zero, so writes to it are dropped here.
    assign bus.wb_wr_data = bus.out_wb[WB_MEMTOREG] ? bus.out_mem_data : bus.out_alu_result;
    assign bus.wb_wr_en   = w_out_fire & bus.out_wb[WB_REGWRITE] & (bus.out_wr_reg != '0);

    // A retirement during a flush cycle still counts; the counter saturates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (w_out_fire && (r_retire_cnt != c_CNT_MAX)) begin
            r_retire_cnt <= r_retire_cnt + c_CNT_ONE;
        end
    end

    assign bus.retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_skid_stage
// Purpose  : Directed plus short random scoreboard bench for mem_wb_skid_stage.
// Revision : 1.0
// ============================================================================
module tb_mem_wb_skid_stage;
    import mem_wb_skid_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    mem_wb_skid_stage_if #(.CNT_W(16)) bus ();
    mem_wb_skid_stage_if #(.CNT_W(2))  bus2 ();

    mem_wb_skid_stage #(.CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    mem_wb_skid_stage #(.CNT_W(2)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus2)
    );

    assign bus2.in_valid      = bus.in_valid;
    assign bus2.in_mem_data   = bus.in_mem_data;
    assign bus2.in_alu_result = bus.in_alu_result;
    assign bus2.in_wr_reg     = bus.in_wr_reg;
    assign bus2.in_wb         = bus.in_wb;
    assign bus2.out_ready     = bus.out_ready;

    always #5 clk = ~clk;

    mem_wb_payload_t q[$];
    int              tests = 0;
    int              fails = 0;
    logic [15:0]     exp_cnt = '0;
    logic [1:0]      exp_cnt2 = '0;
    bit              zeroed = 1'b0;
    bit              live = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check the model's view, advance the model, clock.
    task automatic step(input logic v, input logic [31:0] md, input logic [31:0] alu,
                        input logic [4:0] rg, input logic [1:0] wb,
                        input logic ordy, input logic fl, input logic rst_n);
        bit ifire;
        bit ofire;
        mem_wb_payload_t e;
        bus.in_valid      = v;
        bus.in_mem_data   = md;
        bus.in_alu_result = alu;
        bus.in_wr_reg     = rg;
        bus.in_wb         = wb;
        bus.out_ready     = ordy;
        flush             = fl;
        reset             = rst_n;
        #1;
        ofire = (q.size() > 0) && ordy;
        ifire = v && (q.size() < 2);
        if (live) begin
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() > 0});
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, q.size() < 2});
            chk("retire_cnt", {48'd0, bus.retire_cnt}, {48'd0, exp_cnt});
            chk("retire_cnt_sat", {62'd0, bus2.retire_cnt}, {62'd0, exp_cnt2});
            if (q.size() > 0) begin
                chk("out_mem_data", {32'd0, bus.out_mem_data}, {32'd0, q[0].mem_data});
                chk("out_alu_result", {32'd0, bus.out_alu_result}, {32'd0, q[0].alu_result});
                chk("out_wr_reg", {59'd0, bus.out_wr_reg}, {59'd0, q[0].wr_reg});
                chk("out_wb", {62'd0, bus.out_wb}, {62'd0, q[0].wb});
                chk("wb_wr_data", {32'd0, bus.wb_wr_data},
                    {32'd0, q[0].wb[1] ? q[0].mem_data : q[0].alu_result});
                chk("wb_wr_en", {63'd0, bus.wb_wr_en},
                    {63'd0, ofire && q[0].wb[0] && (q[0].wr_reg != 5'd0)});
            end else begin
                chk("wb_wr_en_idle", {63'd0, bus.wb_wr_en}, 64'd0);
            end
            if (zeroed) begin
                chk("zero_payload", {bus.out_mem_data, bus.out_alu_result} ^
                    {57'd0, bus.out_wr_reg, bus.out_wb}, 64'd0);
            end
        end
        if (!rst_n) begin
            q.delete();
            exp_cnt  = '0;
            exp_cnt2 = '0;
            zeroed   = 1'b1;
        end else begin
            if (ofire) begin
                void'(q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
                if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
            end
            if (fl) begin
                q.delete();
                zeroed = 1'b1;
            end else if (ifire) begin
                e.mem_data   = md;
                e.alu_result = alu;
                e.wr_reg     = rg;
                e.wb         = wb;
                q.push_back(e);
                zeroed = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        live = 1'b1;
        idle(1'b0, 1);

        // Streaming with out_ready held high
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h0, 32'h10 + i, 5'd3, 2'b01, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 2);
        chk("stream_cnt", {48'd0, bus.retire_cnt}, 64'd4);

        // Backpressure: A held, B in skid, C refused while full
        step(1'b1, 32'h0, 32'hA, 5'd4, 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0, 32'hB, 5'd5, 2'b01, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 2);
        step(1'b1, 32'h0, 32'hC, 5'd6, 2'b01, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 3);

        // MemToReg select and register-0 suppression
        step(1'b1, 32'hDEADBEEF, 32'h4, 5'd7, 2'b11, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'hDEADBEEF, 32'h4, 5'd0, 2'b11, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 2);

        // Flush with both entries full and a new input offered
        step(1'b1, 32'h0, 32'hD, 5'd1, 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0, 32'hE, 5'd2, 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0, 32'hF, 5'd3, 2'b01, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 2);

        // Flush coinciding with a retirement still counts it
        step(1'b1, 32'h0, 32'h6, 5'd8, 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0, 32'h7, 5'd9, 2'b01, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 2);

        // Reset mid-stall
        step(1'b1, 32'h1, 32'h11, 5'd1, 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h2, 32'h22, 5'd2, 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h3, 32'h33, 5'd3, 2'b01, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1);
        chk("reset_cnt", {48'd0, bus.retire_cnt}, 64'd0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h0, 32'h40 + i, 5'd2, 2'b01, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 3);
        chk("sat_cnt", {62'd0, bus2.retire_cnt}, 64'd3);

        // Short random traffic
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), 1'b1);
        idle(1'b1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised MEM/WB pipeline boundary register with valid/ready handshake, 2-entry skid buffer, flush, and a built-in writeback select.
- Sits between the data-memory stage and register-file writeback.
- Lets the MEM stage run full rate while WB stalls, and provides a retired-instruction counter.

Parameters:
- DATA_W, 32, width of memory read data, ALU result and writeback data
- REG_AW, 5, register-file address width
- WB_W, 2, WB control width; bit0 = RegWrite, bit1 = MemToReg, upper bits pass through
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_mem_data  in  DATA_W  memory read data
- in_alu_result  in  DATA_W  ALU / R-type result
- in_wr_reg  in  REG_AW  destination register
- in_wb  in  WB_W  WB control
- out_valid  out  1  main entry valid
- out_ready  in  1  WB consumer accepts
- out_mem_data, out_alu_result  out  DATA_W  main entry payload
- out_wr_reg  out  REG_AW  main entry destination
- out_wb  out  WB_W  main entry control
- wb_wr_en  out  1  register-file write strobe
- wb_wr_data  out  DATA_W  selected writeback data
- retire_cnt  out  CNT_W  retired entry count

Behaviour:
- State: main entry (m_valid + payload), skid entry (s_valid + payload), retire counter.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = m_valid & out_ready.
  - out_valid = m_valid.
- Reset (reset==0 at edge):
  - m_valid, s_valid, and all payload registers go to 0; retire_cnt goes to 0.
  - in_ready reads 1 from the next cycle on.
  - Reset overrides flush and all transfers, including mid-stall.
- Flush (reset==1, flush==1):
  - m_valid and s_valid go to 0; payloads are zeroed.
  - Any same-cycle in_fire is dropped and the counter does not increment.
  - A same-cycle out_fire still counts as retired.
- Normal update, evaluated per edge in priority order:
  - Main empty, or out_fire this cycle:
    - If s_valid: skid moves to main, s_valid goes to 0; a same-cycle in_fire is impossible since in_ready=0.
    - Else if in_fire: input loads main.
    - Else m_valid goes to 0.
  - Main full and !out_ready:
    - in_fire loads skid (s_valid goes to 1); main holds.
- Latency and throughput:
  - Latency from in_fire to out_valid is 1 cycle when empty.
  - Sustained throughput is 1 entry/cycle with out_ready held high.
  - Ordering is strictly FIFO; no entry is dropped or duplicated except by flush.
- in_ready drops the cycle after the skid fills and returns the cycle after the skid drains.
- Payload must hold stable while out_valid & !out_ready.
- Writeback (combinational from main):
  - wb_wr_data = out_wb[1] ? out_mem_data : out_alu_result.
  - wb_wr_en = out_fire & out_wb[0] & (out_wr_reg != 0). Writes to register 0 are suppressed.
- retire_cnt:
  - +1 on each out_fire.
  - Saturates at all-ones and does not wrap.

Decomposition:
- Shared pipeline package holds:
  - WB bit index constants: WB_REGWRITE=0, WB_MEMTOREG=1.
  - The default widths: DATA_W, REG_AW, WB_W.
  - A packed MEM/WB payload typedef made of mem_data, alu_result, wr_reg, wb.
- One natural sub-module, pipe_skid_buffer: a generic payload-width 2-entry valid/ready skid register.
- mem_wb_skid_stage wraps pipe_skid_buffer and adds the writeback select, the write-enable qualification and the retire counter.

Test Plan:
- Reset mid-stall: fill both entries, drive reset=0 for 1 cycle → next cycle out_valid=0, in_ready=1, retire_cnt=0, all out_* = 0.
- Streaming: out_ready=1, 4 back-to-back entries with alu_result 0x10..0x13, wb=01, wr_reg=3 → out 1 cycle later in order, wb_wr_en high 4 cycles, wb_wr_data 0x10..0x13, retire_cnt=4.
- Backpressure: out_ready=0, send A then B → A held on out, B in skid, in_ready=0 the cycle after B accepted; raise out_ready → A then B in consecutive cycles, in_ready=1 after skid drains.
- MemToReg/$0: wb=11, mem_data=0xDEADBEEF, alu=0x4, wr_reg=7 → wb_wr_data=0xDEADBEEF, wb_wr_en=1; same entry with wr_reg=0 → wb_wr_en=0 while retire_cnt still increments.
- Flush: both entries full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed input never appears, retire_cnt unchanged.
- Saturation: CNT_W=2, retire 5 entries → retire_cnt reads 3 and stays 3.
